// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT widths plus complex pack/unpack, sign-extend and scale helpers
package fft_pkg;
  localparam int DEF_DBW = 8;
  localparam int MAXW = 32;
  function automatic logic [2*MAXW-1:0] cmask(input int w);
    return {2*MAXW{1'b1}} >> (2*MAXW - w);
  endfunction
  function automatic logic [2*MAXW-1:0] cpack(input logic [MAXW-1:0] re, input logic [MAXW-1:0] im, input int w);
    return (((2*MAXW)'(re) & cmask(w)) << w) | ((2*MAXW)'(im) & cmask(w));
  endfunction
  function automatic logic [MAXW-1:0] cre(input logic [2*MAXW-1:0] v, input int w);
    return MAXW'((v >> w) & cmask(w));
  endfunction
  function automatic logic [MAXW-1:0] cim(input logic [2*MAXW-1:0] v, input int w);
    return MAXW'(v & cmask(w));
  endfunction
  function automatic logic signed [MAXW-1:0] sext(input logic [MAXW-1:0] v, input int w);
    return $signed(v << (MAXW - w)) >>> (MAXW - w);
  endfunction
  function automatic logic signed [MAXW-1:0] scl(input logic signed [MAXW-1:0] v, input bit en);
    return en ? v >>> 1 : v;
  endfunction
endpackage

// File: rtl/fft_delay_ram.sv
// fft_delay_ram: 2**LOGD x W delay memory, synchronous write, combinational read, no reset
module fft_delay_ram #(
  parameter int W = 18,
  parameter int LOGD = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [LOGD-1:0] addr,
  input  logic [W-1:0]    wd,
  output logic [W-1:0]    rd
);
  logic [W-1:0] mem [2**LOGD];
  assign rd = mem[addr];
  // write port; the read above sees the old word in the same cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end
endmodule

// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage: radix-2 SDF butterfly stage; SDF_R2_STAGE_SCALE_EN halves outputs to keep DBW
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter int DBW = DEF_DBW,
  parameter int LOGD = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic in_valid,
  input  logic [2*DBW-1:0] din,
  output logic out_valid,
  output logic out_sop,
`ifdef SDF_R2_STAGE_SCALE_EN
  output logic [2*DBW-1:0] dout
`else
  output logic [2*DBW+1:0] dout
`endif
);
`ifdef SDF_R2_STAGE_SCALE_EN
  localparam int OBW = DBW;
  localparam bit SC = 1'b1;
`else
  localparam int OBW = DBW + 1;
  localparam bit SC = 1'b0;
`endif
  localparam int CW = DBW + 1;
  logic [LOGD:0] cnt;
  logic primed;
  logic phase;
  logic [LOGD-1:0] addr;
  logic [2*OBW-1:0] rd, wd, sw, dw, fw;
  logic signed [CW-1:0] ar, ai, br, bi, sr, si, dr, di;
  assign phase = cnt[LOGD];
  assign addr = cnt[LOGD-1:0];
  fft_delay_ram #(.W(2*OBW), .LOGD(LOGD)) u_ram (
    .clk (clk),
    .we  (in_valid),
    .addr(addr),
    .wd  (wd),
    .rd  (rd)
  );
  // butterfly at DBW+1 so neither sum nor difference can overflow before optional halving
  always_comb begin
    ar = CW'(sext(cre((2*MAXW)'(rd), OBW), OBW));
    ai = CW'(sext(cim((2*MAXW)'(rd), OBW), OBW));
    br = CW'(sext(cre((2*MAXW)'(din), DBW), DBW));
    bi = CW'(sext(cim((2*MAXW)'(din), DBW), DBW));
    sr = ar + br;
    si = ai + bi;
    dr = ar - br;
    di = ai - bi;
    sw = (2*OBW)'(cpack(scl(MAXW'(sr), SC), scl(MAXW'(si), SC), OBW));
    dw = (2*OBW)'(cpack(scl(MAXW'(dr), SC), scl(MAXW'(di), SC), OBW));
    fw = (2*OBW)'(cpack(MAXW'(br), MAXW'(bi), OBW));
    wd = phase ? dw : fw;
  end
  // sample counter and priming flag; primed marks that stored differences are real
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt <= cnt + 1'b1;
      if (&cnt) primed <= 1'b1;
    end
  end
  // registered output: sums in the butterfly phase, drained differences in the fill phase
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      dout <= '0;
    end else begin
      out_valid <= in_valid & (phase | primed);
      out_sop <= in_valid & phase & (addr == '0);
      if (in_valid) dout <= phase ? sw : rd;
    end
  end
endmodule

// File: tb/tb_sdf_r2_stage.sv
// tb_sdf_r2_stage: randomized and directed checks of sdf_r2_stage against a block-level model
module tb_sdf_r2_stage;
  localparam int DBW = 8;
  localparam int LOGD = 2;
  localparam int D = 1 << LOGD;
`ifdef SDF_R2_STAGE_SCALE_EN
  localparam int OBW = DBW;
  localparam bit SC = 1'b1;
`else
  localparam int OBW = DBW + 1;
  localparam bit SC = 1'b0;
`endif
  logic clk = 1'b0;
  logic clear = 1'b1;
  logic in_valid = 1'b0;
  logic [2*DBW-1:0] din = '0;
  logic out_valid, out_sop;
  logic [2*OBW-1:0] dout;
  int errors = 0;
  int checks = 0;
  int xr [D], xi [D], pr [D], pi [D];
  int k = 0;
  bit primed = 1'b0;
  bit ev = 1'b0, es = 1'b0;
  int er = 0, ei = 0;
  int tr [8] = '{127, -128, 127, 3, 127, -128, -128, 0};
  int ti [8] = '{127, -128, 0, -3, 127, -128, 0, 0};

  sdf_r2_stage #(.DBW(DBW), .LOGD(LOGD)) dut (
    .clk      (clk),
    .clear    (clear),
    .in_valid (in_valid),
    .din      (din),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sc(input int v);
    return SC ? (v >>> 1) : v;
  endfunction

  function automatic int sx(input logic [OBW-1:0] v);
    return $signed(v);
  endfunction

  task automatic step(input bit v, input int r, input int i);
    in_valid = v;
    din = {DBW'(r), DBW'(i)};
    @(posedge clk);
    ev = 1'b0;
    es = 1'b0;
    if (v) begin
      if (k < D) begin
        ev = primed;
        er = pr[k];
        ei = pi[k];
        xr[k] = r;
        xi[k] = i;
      end else begin
        ev = 1'b1;
        es = (k == D);
        er = sc(xr[k-D] + r);
        ei = sc(xi[k-D] + i);
        pr[k-D] = sc(xr[k-D] - r);
        pi[k-D] = sc(xi[k-D] - i);
      end
      if (k == 2*D-1) primed = 1'b1;
      k = (k + 1) % (2*D);
    end
    #1;
    chk("valid", int'(out_valid), int'(ev));
    chk("sop", int'(out_sop), int'(es));
    if (ev) begin
      chk("re", sx(dout[2*OBW-1:OBW]), er);
      chk("im", sx(dout[OBW-1:0]), ei);
    end
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    #2 clear = 1'b1;
    #1;
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_sop", int'(out_sop), 0);
    chk("clr_dout", int'(dout), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    k = 0;
    primed = 1'b0;
    ev = 1'b0;
    es = 1'b0;
  endtask

  initial begin
    int n, c;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sop", int'(out_sop), 0);
    chk("rst_dout", int'(dout), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    for (int j = 1; j <= 16; j++) step(1'b1, j, 0);
    for (int j = 0; j < D; j++) step(1'b1, 0, 0);
    do_clear();
    n = 1;
    c = 0;
    while (n <= 16) begin
      if (c % 3 == 2) step(1'b0, 0, 0);
      else begin
        step(1'b1, n, 0);
        n++;
      end
      c++;
    end
    do_clear();
    for (int j = 0; j < 16; j++) step(1'b1, tr[j%8], ti[j%8]);
    for (int j = 0; j < D; j++) step(1'b1, 0, 0);
    do_clear();
    for (int j = 1; j <= 14; j++) step(1'b1, j, -j);
    do_clear();
    for (int j = 0; j < 12; j++) step(1'b1, 10 * j - 50, 3 * j);
    for (int j = 0; j < 300; j++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdf_r2_stage.md
Name: sdf_r2_stage

Overview:
- Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT pipeline.
- Takes one complex sample per accepted cycle and uses an internal delay memory of depth D = 2**LOGD.
- Emits butterfly sums x[n]+x[n+D] and differences x[n]-x[n+D] in stream order, with valid gating and a block-start marker.
- Cascaded stages with decreasing LOGD form the full FFT; twiddle multiplication lives in a separate downstream block.

Parameters:
- DBW, 8: input bit width per component (re/im), two's complement.
- LOGD, 2: log2 of delay depth D; block length is 2*D. LOGD >= 1.

Ports:
- clk  in  1: clock, rising edge.
- clear  in  1: reset, asynchronous, active-high.
- in_valid  in  1: din is accepted this cycle.
- din  in  2*DBW: {re[2*DBW-1:DBW], im[DBW-1:0]}.
- out_valid  out  1: dout is valid this cycle.
- out_sop  out  1: dout is the sum for index n=0 of a block.
- dout  out  2*OBW: {re, im}; OBW = DBW+1 (DBW when scaling is enabled).

Behaviour:
- Counter cnt, LOGD+1 bits, increments only on in_valid and wraps 2*D-1 -> 0.
- phase = cnt[LOGD]; addr = cnt[LOGD-1:0]. Delay memory reads before it writes at the same addr.
- Input is sign-extended to OBW before arithmetic. Arithmetic is two's complement and never saturates.
- Fill phase (phase=0, in_valid):
  - mem[addr] <= din.
  - The previous block's stored difference mem[addr] is driven to dout on the next clock.
  - out_valid=1 only if primed=1. out_sop=0.
- Butterfly phase (phase=1, in_valid):
  - a = mem[addr], b = din.
  - dout <= a+b, registered, available the next clock.
  - mem[addr] <= a-b (stored in OBW-wide form).
  - out_valid=1. out_sop=1 iff addr==0.
- primed:
  - Set when an accepted sample has cnt==2*D-1.
  - Cleared only by clear. Differences therefore drain only while the next block is being fed.
- Latency:
  - Sum X[n] appears 1 clk after x[n+D] is accepted.
  - Difference for n appears 1 clk after x[n] of the following block is accepted.
- in_valid=0:
  - cnt and mem hold. out_valid=0 and out_sop=0 next cycle.
  - dout holds its last value.
- Memory width is 2*OBW so stored differences keep their growth bit.
- Reset (clear=1, asynchronous, any time including mid-block):
  - cnt=0, primed=0, out_valid=0, out_sop=0, dout=0.
  - Memory contents are not reset. They are unreachable until rewritten, because primed=0.
- Back-to-back blocks with no bubbles are supported at one sample per clock.

Optional Feature:
- Macro: SDF_R2_STAGE_SCALE_EN.
- Defined:
  - OBW = DBW. Sum and difference are computed at DBW+1 and then arithmetically shifted right by 1 (floor).
  - The stored difference is already scaled.
- Undefined:
  - OBW = DBW+1 and no shift is applied; the output carries the full growth bit.

Decomposition:
- Shared package fft_pkg holds:
  - default DBW;
  - complex pack/unpack helper functions (re upper, im lower);
  - sign-extend and scale helper functions.
- One sub-module: fft_delay_ram. Parameters: width W and depth 2**LOGD. Synchronous write, combinational read, no reset. Reused by later stages.

Test Plan:
- Ramp: DBW=8, LOGD=2; feed re=1..8, im=0, then re=9..16 with no bubbles.
  - Sums 6,8,10,12 (out_sop on the 6).
  - Then differences -4,-4,-4,-4, interleaved with the second block's sums 22,24,26,28.
- Priming: after clear, feed the first 4 samples.
  - out_valid stays 0 throughout. First out_valid is 1 clk after the 5th sample.
- Bubbles: same ramp with in_valid low every 3rd cycle.
  - Identical output value sequence. out_valid=0 exactly 1 clk after each bubble.
- Extremes, no scale: a=127+127j, b=127+127j -> sum 254+254j, difference 0.
  - a=b=-128 -> sum -256 (OBW=9). a=127, b=-128 -> difference 255.
- Scale (SDF_R2_STAGE_SCALE_EN):
  - 127+127 -> 127; -128+-128 -> -128; 3+0 -> 1; -3+0 -> -2.
- Mid-block reset: assert clear after 6 samples of block 2.
  - Outputs go to 0 immediately. The next 4 samples produce out_valid=0. The following sums are correct.
